// File: rtl/dual_port_blockram_pkg.sv
// Shared constants for the dual-port block RAM: byte width, read-during-write
// encodings and port indices.
package dual_port_blockram_pkg;

  localparam int unsigned BYTE_LEN_IN_BITS = 8;

  // Same-port read-during-write behaviour
  localparam int unsigned RDW_READ_FIRST  = 0;
  localparam int unsigned RDW_WRITE_FIRST = 1;

  localparam int unsigned NUM_PORTS = 2;
  localparam int unsigned PORT_A    = 0;
  localparam int unsigned PORT_B    = 1;

endpackage

// File: rtl/dual_port_blockram_read_pipeline.sv
// Delay line of NUM_STAGES data/valid registers behind the RAM output register.
// Each data register only loads with a valid beat, so the output holds between pulses.
module blockram_read_pipeline #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned NUM_STAGES = 0
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data
);

  if (NUM_STAGES == 0) begin : g_bypass
    logic w_unused;
    assign w_unused = &{1'b0, i_clk, i_reset_n};
    assign o_valid  = i_valid;
    assign o_data   = i_data;
  end else begin : g_pipe
    for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
      logic                  w_valid_in;
      logic [DATA_WIDTH-1:0] w_data_in;
      logic                  r_valid;
      logic [DATA_WIDTH-1:0] r_data;

      if (gi == 0) begin : g_first
        assign w_valid_in = i_valid;
        assign w_data_in  = i_data;
      end else begin : g_chain
        assign w_valid_in = g_stage[gi-1].r_valid;
        assign w_data_in  = g_stage[gi-1].r_data;
      end

      always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
          r_valid <= 1'b0;
          r_data  <= '0;
        end else begin
          r_valid <= w_valid_in;
          if (w_valid_in) begin
            r_data <= w_data_in;
          end
        end
      end
    end

    assign o_valid = g_stage[NUM_STAGES-1].r_valid;
    assign o_data  = g_stage[NUM_STAGES-1].r_data;
  end

endmodule

// File: rtl/dual_port_blockram.sv
// True dual-port byte-writable RAM with a configurable read latency; every accepted
// access (read or write) returns one data beat READ_LATENCY cycles later.
module dual_port_blockram
  import dual_port_blockram_pkg::*;
#(
  parameter int unsigned SINGLE_ENTRY_SIZE_IN_BITS = 64,
  parameter int unsigned NUM_SET                   = 64,
  parameter int unsigned SET_PTR_WIDTH_IN_BITS     = $clog2(NUM_SET),
  parameter int unsigned WRITE_MASK_LEN            = SINGLE_ENTRY_SIZE_IN_BITS / BYTE_LEN_IN_BITS,
  parameter int unsigned READ_LATENCY              = 1,
  parameter int unsigned READ_DURING_WRITE_MODE    = RDW_READ_FIRST
) (
  input  logic                                 clk_in,
  input  logic                                 reset_in,
  input  logic                                 access_en_a_in,
  input  logic [WRITE_MASK_LEN-1:0]            write_en_a_in,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0]     access_set_addr_a_in,
  input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] write_entry_a_in,
  output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] read_entry_a_out,
  output logic                                 read_valid_a_out,
  input  logic                                 access_en_b_in,
  input  logic [WRITE_MASK_LEN-1:0]            write_en_b_in,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0]     access_set_addr_b_in,
  input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] write_entry_b_in,
  output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] read_entry_b_out,
  output logic                                 read_valid_b_out
);

  localparam int unsigned W = SINGLE_ENTRY_SIZE_IN_BITS;
  localparam int unsigned B = BYTE_LEN_IN_BITS;
  localparam logic [SET_PTR_WIDTH_IN_BITS:0] NUM_SET_EXT = (SET_PTR_WIDTH_IN_BITS + 1)'(NUM_SET);

  logic                             w_en       [NUM_PORTS];
  logic [WRITE_MASK_LEN-1:0]        w_we       [NUM_PORTS];
  logic [SET_PTR_WIDTH_IN_BITS-1:0] w_addr     [NUM_PORTS];
  logic [W-1:0]                     w_wdata    [NUM_PORTS];
  logic                             w_in_range [NUM_PORTS];
  logic                             w_valid_out[NUM_PORTS];
  logic [W-1:0]                     w_data_out [NUM_PORTS];

  logic [W-1:0] r_mem [NUM_SET];

  assign w_en[PORT_A]    = access_en_a_in;
  assign w_we[PORT_A]    = write_en_a_in;
  assign w_addr[PORT_A]  = access_set_addr_a_in;
  assign w_wdata[PORT_A] = write_entry_a_in;
  assign w_en[PORT_B]    = access_en_b_in;
  assign w_we[PORT_B]    = write_en_b_in;
  assign w_addr[PORT_B]  = access_set_addr_b_in;
  assign w_wdata[PORT_B] = write_entry_b_in;

  // Port b is written first so port a's enabled bytes win on an address collision
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      if (w_en[PORT_B] && w_in_range[PORT_B]) begin
        for (int i = 0; i < int'(WRITE_MASK_LEN); i++) begin
          if (w_we[PORT_B][i]) begin
            r_mem[w_addr[PORT_B]][i*B +: B] <= w_wdata[PORT_B][i*B +: B];
          end
        end
      end
      if (w_en[PORT_A] && w_in_range[PORT_A]) begin
        for (int i = 0; i < int'(WRITE_MASK_LEN); i++) begin
          if (w_we[PORT_A][i]) begin
            r_mem[w_addr[PORT_A]][i*B +: B] <= w_wdata[PORT_A][i*B +: B];
          end
        end
      end
    end
  end

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    logic [W-1:0] w_old;
    logic [W-1:0] w_return;
    logic         r_valid;
    logic [W-1:0] r_rdata;

    assign w_in_range[gi] = ({1'b0, w_addr[gi]} < NUM_SET_EXT);
    assign w_old          = r_mem[w_addr[gi]];

    // Write-first returns this port's own merge only; the other port's write is never seen
    if (READ_DURING_WRITE_MODE == RDW_WRITE_FIRST) begin : g_write_first
      for (genvar gj = 0; gj < WRITE_MASK_LEN; gj++) begin : g_byte
        assign w_return[gj*B +: B] = w_we[gi][gj] ? w_wdata[gi][gj*B +: B] : w_old[gj*B +: B];
      end
    end else begin : g_read_first
      assign w_return = w_old;
    end

    always_ff @(posedge clk_in) begin
      if (!reset_in) begin
        r_valid <= 1'b0;
        r_rdata <= '0;
      end else begin
        r_valid <= w_en[gi];
        if (w_en[gi]) begin
          r_rdata <= w_in_range[gi] ? w_return : '0;
        end
      end
    end

    blockram_read_pipeline #(
      .DATA_WIDTH(W),
      .NUM_STAGES(READ_LATENCY - 1)
    ) u_read_pipeline (
      .i_clk    (clk_in),
      .i_reset_n(reset_in),
      .i_valid  (r_valid),
      .i_data   (r_rdata),
      .o_valid  (w_valid_out[gi]),
      .o_data   (w_data_out[gi])
    );
  end

  assign read_valid_a_out = w_valid_out[PORT_A];
  assign read_entry_a_out = w_data_out[PORT_A];
  assign read_valid_b_out = w_valid_out[PORT_B];
  assign read_entry_b_out = w_data_out[PORT_B];

endmodule

// File: tb/tb_dual_port_blockram.sv
// Directed bench: two latency-1 instances (read-first / write-first) share one vector
// table; a latency-3, 48-entry instance runs the burst, range and reset sequences.
module tb_dual_port_blockram;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Latency-1 instances, shared stimulus
  logic        rst_n;
  logic        en_a, en_b;
  logic [7:0]  we_a, we_b;
  logic [5:0]  addr_a, addr_b;
  logic [63:0] wd_a, wd_b;
  logic [63:0] m0_da, m0_db, m1_da, m1_db;
  logic        m0_va, m0_vb, m1_va, m1_vb;

  // Latency-3 instance
  logic        c_rst_n;
  logic        c_en_a, c_en_b;
  logic [7:0]  c_we_a, c_we_b;
  logic [5:0]  c_addr_a, c_addr_b;
  logic [63:0] c_wd_a, c_wd_b;
  logic [63:0] c_da, c_db;
  logic        c_va, c_vb;

  dual_port_blockram #(.READ_LATENCY(1), .READ_DURING_WRITE_MODE(0)) dut_m0 (
    .clk_in(clk), .reset_in(rst_n),
    .access_en_a_in(en_a), .write_en_a_in(we_a), .access_set_addr_a_in(addr_a),
    .write_entry_a_in(wd_a), .read_entry_a_out(m0_da), .read_valid_a_out(m0_va),
    .access_en_b_in(en_b), .write_en_b_in(we_b), .access_set_addr_b_in(addr_b),
    .write_entry_b_in(wd_b), .read_entry_b_out(m0_db), .read_valid_b_out(m0_vb)
  );

  dual_port_blockram #(.READ_LATENCY(1), .READ_DURING_WRITE_MODE(1)) dut_m1 (
    .clk_in(clk), .reset_in(rst_n),
    .access_en_a_in(en_a), .write_en_a_in(we_a), .access_set_addr_a_in(addr_a),
    .write_entry_a_in(wd_a), .read_entry_a_out(m1_da), .read_valid_a_out(m1_va),
    .access_en_b_in(en_b), .write_en_b_in(we_b), .access_set_addr_b_in(addr_b),
    .write_entry_b_in(wd_b), .read_entry_b_out(m1_db), .read_valid_b_out(m1_vb)
  );

  dual_port_blockram #(.NUM_SET(48), .READ_LATENCY(3), .READ_DURING_WRITE_MODE(0)) dut_l3 (
    .clk_in(clk), .reset_in(c_rst_n),
    .access_en_a_in(c_en_a), .write_en_a_in(c_we_a), .access_set_addr_a_in(c_addr_a),
    .write_entry_a_in(c_wd_a), .read_entry_a_out(c_da), .read_valid_a_out(c_va),
    .access_en_b_in(c_en_b), .write_en_b_in(c_we_b), .access_set_addr_b_in(c_addr_b),
    .write_entry_b_in(c_wd_b), .read_entry_b_out(c_db), .read_valid_b_out(c_vb)
  );

  typedef struct {
    logic        en_a;
    logic [7:0]  we_a;
    logic [5:0]  addr_a;
    logic [63:0] wd_a;
    logic        en_b;
    logic [7:0]  we_b;
    logic [5:0]  addr_b;
    logic [63:0] wd_b;
    logic        chk_da;
    logic        exp_va;
    logic [63:0] exp_da0;
    logic [63:0] exp_da1;
    logic        chk_db;
    logic        exp_vb;
    logic [63:0] exp_db0;
    logic [63:0] exp_db1;
  } vec_t;

  localparam int NVEC = 11;
  vec_t vecs [NVEC];

  int n_checks = 0;
  int n_fail   = 0;
  logic exp_v;

  localparam logic [63:0] F0   = 64'hFFFFFFFF00000000;
  localparam logic [63:0] ONES = 64'hFFFFFFFFFFFFFFFF;
  localparam logic [63:0] MSK  = 64'hFFFF0000FFFF0000;
  localparam logic [63:0] D11  = 64'h1111111111111111;
  localparam logic [63:0] D22  = 64'h2222222222222222;
  localparam logic [63:0] DAA  = 64'hAAAAAAAAAAAAAAAA;
  localparam logic [63:0] DBB  = 64'hBBBBBBBBBBBBBBBB;
  localparam logic [63:0] DBA  = 64'hBBBBBBBBAAAAAAAA;
  localparam logic [63:0] D0A  = 64'h00000000AAAAAAAA;

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b, expected %0b", name, act, exp);
    end
  endtask

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic c_drive(input logic en, input logic [7:0] we, input logic [5:0] addr,
                         input logic [63:0] wd);
    c_en_a   = en;
    c_we_a   = we;
    c_addr_a = addr;
    c_wd_a   = wd;
  endtask

  initial begin
    rst_n = 1'b0; c_rst_n = 1'b0;
    en_a = 0; we_a = 0; addr_a = 0; wd_a = 0;
    en_b = 0; we_b = 0; addr_b = 0; wd_b = 0;
    c_en_a = 0; c_we_a = 0; c_addr_a = 0; c_wd_a = 0;
    c_en_b = 0; c_we_b = 0; c_addr_b = 0; c_wd_b = 0;

    //          en_a we_a   addr_a wd_a  en_b we_b   addr_b wd_b  chkA va da(m0) da(m1)  chkB vb db(m0) db(m1)
    vecs[0]  = '{1'b1, 8'hFF, 6'd63, 64'h0, 1'b1, 8'hFF, 6'd62, 64'h0, 1'b0, 1'b1, 64'h0, 64'h0, 1'b0, 1'b1, 64'h0, 64'h0};
    vecs[1]  = '{1'b1, 8'hFF, 6'd10, D11,   1'b1, 8'hFF, 6'd5,  64'h0, 1'b0, 1'b1, 64'h0, 64'h0, 1'b0, 1'b1, 64'h0, 64'h0};
    vecs[2]  = '{1'b1, 8'hFF, 6'd63, F0,    1'b0, 8'h00, 6'd0,  64'h0, 1'b1, 1'b1, 64'h0, F0,    1'b0, 1'b0, 64'h0, 64'h0};
    vecs[3]  = '{1'b1, 8'h00, 6'd63, 64'h0, 1'b0, 8'h00, 6'd0,  64'h0, 1'b1, 1'b1, F0,    F0,    1'b0, 1'b0, 64'h0, 64'h0};
    vecs[4]  = '{1'b0, 8'h00, 6'd0,  64'h0, 1'b1, 8'hCC, 6'd62, ONES,  1'b1, 1'b0, F0,    F0,    1'b1, 1'b1, 64'h0, MSK};
    vecs[5]  = '{1'b0, 8'h00, 6'd0,  64'h0, 1'b1, 8'h00, 6'd62, 64'h0, 1'b1, 1'b0, F0,    F0,    1'b1, 1'b1, MSK,   MSK};
    vecs[6]  = '{1'b1, 8'hFF, 6'd10, D22,   1'b1, 8'h00, 6'd10, 64'h0, 1'b1, 1'b1, D11,   D22,   1'b1, 1'b1, D11,   D11};
    vecs[7]  = '{1'b1, 8'h00, 6'd10, 64'h0, 1'b1, 8'h00, 6'd10, 64'h0, 1'b1, 1'b1, D22,   D22,   1'b1, 1'b1, D22,   D22};
    vecs[8]  = '{1'b1, 8'h0F, 6'd5,  DAA,   1'b1, 8'hFF, 6'd5,  DBB,   1'b1, 1'b1, 64'h0, D0A,   1'b1, 1'b1, 64'h0, DBB};
    vecs[9]  = '{1'b1, 8'h00, 6'd5,  64'h0, 1'b0, 8'h00, 6'd0,  64'h0, 1'b1, 1'b1, DBA,   DBA,   1'b1, 1'b0, 64'h0, DBB};
    vecs[10] = '{1'b0, 8'h00, 6'd0,  64'h0, 1'b0, 8'h00, 6'd0,  64'h0, 1'b1, 1'b0, DBA,   DBA,   1'b1, 1'b0, 64'h0, DBB};

    // Reset state of all instances
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_bit("rst_m0_va", m0_va, 1'b0); check64("rst_m0_da", m0_da, 64'h0);
    check_bit("rst_m0_vb", m0_vb, 1'b0); check64("rst_m0_db", m0_db, 64'h0);
    check_bit("rst_m1_va", m1_va, 1'b0); check64("rst_m1_da", m1_da, 64'h0);
    check_bit("rst_l3_va", c_va, 1'b0);  check64("rst_l3_da", c_da, 64'h0);
    $display("reset: outputs checked");
    rst_n = 1'b1; c_rst_n = 1'b1;

    // Table-driven latency-1 vectors
    for (int i = 0; i < NVEC; i++) begin
      en_a = vecs[i].en_a; we_a = vecs[i].we_a; addr_a = vecs[i].addr_a; wd_a = vecs[i].wd_a;
      en_b = vecs[i].en_b; we_b = vecs[i].we_b; addr_b = vecs[i].addr_b; wd_b = vecs[i].wd_b;
      @(negedge clk);
      check_bit($sformatf("v%0d_m0_va", i), m0_va, vecs[i].exp_va);
      check_bit($sformatf("v%0d_m1_va", i), m1_va, vecs[i].exp_va);
      check_bit($sformatf("v%0d_m0_vb", i), m0_vb, vecs[i].exp_vb);
      check_bit($sformatf("v%0d_m1_vb", i), m1_vb, vecs[i].exp_vb);
      if (vecs[i].chk_da) begin
        check64($sformatf("v%0d_m0_da", i), m0_da, vecs[i].exp_da0);
        check64($sformatf("v%0d_m1_da", i), m1_da, vecs[i].exp_da1);
      end
      if (vecs[i].chk_db) begin
        check64($sformatf("v%0d_m0_db", i), m0_db, vecs[i].exp_db0);
        check64($sformatf("v%0d_m1_db", i), m1_db, vecs[i].exp_db1);
      end
      $display("vec %0d: a(en=%0b we=%h addr=%0d) b(en=%0b we=%h addr=%0d) -> m0 a=%h b=%h, m1 a=%h b=%h",
               i, vecs[i].en_a, vecs[i].we_a, vecs[i].addr_a, vecs[i].en_b, vecs[i].we_b,
               vecs[i].addr_b, m0_da, m0_db, m1_da, m1_db);
    end
    en_a = 0; en_b = 0; we_a = 0; we_b = 0;

    // Latency 3: preset addr 0..7, then 8 back-to-back reads
    for (int i = 0; i < 8; i++) begin
      c_drive(1'b1, 8'hFF, 6'(i), {8{8'(i + 1)}});
      @(negedge clk);
    end
    c_drive(1'b0, 8'h00, 6'd0, 64'h0);
    repeat (4) @(negedge clk);
    for (int c = 0; c < 13; c++) begin
      exp_v = (c >= 3 && c <= 10);
      check_bit($sformatf("burst_va_c%0d", c), c_va, exp_v);
      if (exp_v) check64($sformatf("burst_da_c%0d", c), c_da, {8{8'(c - 2)}});
      $display("burst cycle %0d: valid=%0b data=%h", c, c_va, c_da);
      if (c < 8) c_drive(1'b1, 8'h00, 6'(c), 64'h0);
      else       c_drive(1'b0, 8'h00, 6'd0, 64'h0);
      @(negedge clk);
    end

    // Out-of-range address (>= 48): no write, zero data, valid still pulses
    c_drive(1'b1, 8'hFF, 6'd50, 64'hDEADBEEFDEADBEEF); @(negedge clk);
    c_drive(1'b1, 8'h00, 6'd50, 64'h0);                @(negedge clk);
    c_drive(1'b1, 8'h00, 6'd2,  64'h0);                @(negedge clk);
    c_drive(1'b0, 8'h00, 6'd0,  64'h0);
    check_bit("oor_wr_va", c_va, 1'b1); check64("oor_wr_da", c_da, 64'h0);
    @(negedge clk);
    check_bit("oor_rd_va", c_va, 1'b1); check64("oor_rd_da", c_da, 64'h0);
    @(negedge clk);
    check_bit("addr2_va", c_va, 1'b1);  check64("addr2_da", c_da, {8{8'h03}});
    @(negedge clk);
    check_bit("hold_va", c_va, 1'b0);   check64("hold_da", c_da, {8{8'h03}});
    $display("range: out-of-range write/read and addr 2 readback done");

    // Reset with two reads in flight and a write attempt during reset
    c_drive(1'b1, 8'h00, 6'd1, 64'h0); @(negedge clk);
    c_drive(1'b1, 8'h00, 6'd2, 64'h0); @(negedge clk);
    c_rst_n = 1'b0;
    c_drive(1'b1, 8'hFF, 6'd3, 64'hCAFECAFECAFECAFE); @(negedge clk);
    check_bit("inflight_rst_va0", c_va, 1'b0); check64("inflight_rst_da0", c_da, 64'h0);
    @(negedge clk);
    check_bit("inflight_rst_va1", c_va, 1'b0); check64("inflight_rst_da1", c_da, 64'h0);
    c_rst_n = 1'b1;
    c_drive(1'b0, 8'h00, 6'd0, 64'h0); @(negedge clk);
    check_bit("post_rst_va", c_va, 1'b0);
    c_drive(1'b1, 8'h00, 6'd1, 64'h0); @(negedge clk);
    c_drive(1'b1, 8'h00, 6'd3, 64'h0); @(negedge clk);
    c_drive(1'b0, 8'h00, 6'd0, 64'h0); @(negedge clk);
    check_bit("keep_addr1_va", c_va, 1'b1); check64("keep_addr1_da", c_da, {8{8'h02}});
    @(negedge clk);
    check_bit("keep_addr3_va", c_va, 1'b1); check64("keep_addr3_da", c_da, {8{8'h04}});
    $display("reset: in-flight discard and memory retention done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
